ahb_apb_bridge_nslv: RTL and testbench

Parametrised successor to the fixed 4-slave AHB-to-APB bridge. It converts single AHB-Lite transfers into APB4 transfers for NSLV peripherals. Adds PSTRB/PPROT generation, a PREADY timeout, out-of-range slave decode and the two-cycle AHB ERROR response. It sits behind the decoder's bridge chip-select and returns hreadyout/hresp/hrdata to the slave mux.

---
 rtl/ahb_apb_bridge_nslv.sv | 187 ++++++++++++++++++
 tb/tb_ahb_apb_bridge_nslv.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite to APB4 bridge for NSLV peripherals.
// Converts single AHB transfers into APB setup/access pairs. Adds byte strobes,
// protection mapping, a PREADY timeout and the two-cycle AHB ERROR response.
module ahb_apb_bridge_nslv #(
  parameter int NSLV    = 4,
  parameter int AW      = 16,
  parameter int PAW     = 12,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 hsel,
  input  logic [AW-1:0]        haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [3:0]           hprot,
  input  logic [31:0]          hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic [PAW-1:0]       paddr,
  output logic [NSLV-1:0]      psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic [NSLV*32-1:0]   prdata,
  input  logic [NSLV-1:0]      pready,
  input  logic [NSLV-1:0]      pslverr
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW:0]   NSLV_W = (IW+1)'(NSLV);
  localparam logic [CW-1:0] TO_W   = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WCAP, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [PAW-1:0]  r_paddr;
  logic            r_pwrite;
  logic [31:0]     r_pwdata;
  logic [3:0]      r_pstrb;
  logic [2:0]      r_pprot;
  logic            r_hreadyout;
  logic            r_hresp;
  logic [31:0]     r_hrdata;

  logic            w_accept;
  logic [IW-1:0]   w_idx_in;
  logic            w_bad;
  logic [3:0]      w_strb;
  logic            w_pready;
  logic            w_pslverr;
  logic [31:0]     w_prdata;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_timeout;
  logic [NSLV-1:0] w_psel;
  logic            w_penable;
  logic            w_unused;

  assign w_accept  = hsel & hready & htrans[1] &
                     ((r_state == S_IDLE) || (r_state == S_ERR2));
  assign w_idx_in  = haddr[SEL_LSB +: IW];
  assign w_bad     = ({1'b0, w_idx_in} >= NSLV_W) || (hsize > 3'd2);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == TO_W);
  assign w_unused  = ^{haddr, htrans[0], hprot[3:2]};

  // Byte-lane strobes for the accepted transfer; reads never strobe.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_strb = 4'b0000;
    if (hwrite) begin
      case (hsize)
        3'd0:    w_strb = 4'b0001 << haddr[1:0];
        3'd1:    w_strb = haddr[1] ? 4'b1100 : 4'b0011;
        default: w_strb = 4'b1111;
      endcase
    end
  end

  // Pick the selected slave's response; other slaves' pready/pslverr are ignored.
  always_comb begin
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (r_idx == IW'(k)) begin
        w_pready  = pready[k];
        w_pslverr = pslverr[k];
        w_prdata  = prdata[32*k +: 32];
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ERR2: begin
        if (w_accept) begin
          if (w_bad)       w_state_nxt = S_ERR1;
          else if (hwrite) w_state_nxt = S_WCAP;
          else             w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WCAP:   w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_pready)       w_state_nxt = w_pslverr ? S_ERR1 : S_IDLE;
        else if (w_timeout) w_state_nxt = S_ERR1;
      end
      S_ERR1:   w_state_nxt = S_ERR2;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // APB select/enable decoded from the current state and latched slave index.
  always_comb begin
    w_psel    = '0;
    w_penable = (r_state == S_ACCESS);
    for (int k = 0; k < NSLV; k++) begin
      w_psel[k] = ((r_state == S_SETUP) || (r_state == S_ACCESS)) && (r_idx == IW'(k));
    end
  end

  // Transfer attributes, timeout counter and registered AHB response.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      r_hreadyout <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ERR2);
      r_hresp     <= (w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2);
      if (w_accept) begin
        r_idx    <= w_idx_in;
        r_paddr  <= haddr[PAW-1:0];
        r_pwrite <= hwrite;
        r_pstrb  <= w_strb;
        r_pprot  <= {~hprot[0], 1'b1, hprot[1]};
      end
      if (r_state == S_WCAP) r_pwdata <= hwdata;
      if (w_state_nxt == S_SETUP)                r_cnt <= '0;
      else if ((r_state == S_ACCESS) && !w_pready) r_cnt <= w_cnt_inc;
      if ((r_state == S_ACCESS) && w_pready && !w_pslverr && !r_pwrite)
        r_hrdata <= w_prdata;
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;
  assign paddr     = r_paddr;
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign pprot     = r_pprot;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Directed bench for ahb_apb_bridge_nslv: a 4-slave instance for the main
// behaviour and a 3-slave instance for out-of-range decode.
module tb_ahb_apb_bridge_nslv;

  logic        clk;
  logic        rst;
  logic        hsel, hsel3;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;

  logic        hreadyout, hresp, penable, pwrite;
  logic [31:0] hrdata, pwdata;
  logic [11:0] paddr;
  logic [3:0]  psel, pstrb;
  logic [2:0]  pprot;
  logic [127:0] prdata;
  logic [3:0]  pready, pslverr;

  logic        hreadyout3, hresp3, penable3, pwrite3;
  logic [31:0] hrdata3, pwdata3;
  logic [11:0] paddr3;
  logic [2:0]  psel3;
  logic [3:0]  pstrb3;
  logic [2:0]  pprot3;
  logic [95:0] prdata3;
  logic [2:0]  pready3, pslverr3;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_apb_bridge_nslv #(.NSLV(4), .AW(16), .PAW(12), .SEL_LSB(12), .TIMEOUT(16)) dut (
    .hclk(clk), .hreset(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  ahb_apb_bridge_nslv #(.NSLV(3), .AW(16), .PAW(12), .SEL_LSB(12), .TIMEOUT(16)) dut3 (
    .hclk(clk), .hreset(rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3), .paddr(paddr3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .pwdata(pwdata3),
    .pstrb(pstrb3), .pprot(pprot3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one address phase; returns in the cycle after it was sampled.
  task automatic ahb_addr(input logic to3, input logic [15:0] a, input logic w,
                          input logic [2:0] sz, input logic [3:0] pr);
    hsel   = ~to3;
    hsel3  = to3;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    hprot  = pr;
    tick();
    hsel   = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
  endtask

  // Full write to a ready slave with cycle-by-cycle checks.
  task automatic do_write(input string tag, input logic [15:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [3:0] pr, input logic [3:0] e_sel,
                          input logic [3:0] e_strb, input logic [2:0] e_prot);
    ahb_addr(1'b0, a, 1'b1, sz, pr);
    check({tag, "_wcap_rdy"}, 32'(hreadyout), 32'd0);
    check({tag, "_wcap_psel"}, 32'(psel), 32'd0);
    hwdata = d;
    tick();
    hwdata = 32'h0;
    check({tag, "_setup_rdy"}, 32'(hreadyout), 32'd0);
    check({tag, "_setup_psel"}, 32'(psel), 32'(e_sel));
    check({tag, "_setup_pen"}, 32'(penable), 32'd0);
    check({tag, "_paddr"}, 32'(paddr), 32'(a[11:0]));
    check({tag, "_pwrite"}, 32'(pwrite), 32'd1);
    check({tag, "_pstrb"}, 32'(pstrb), 32'(e_strb));
    check({tag, "_pwdata"}, pwdata, d);
    check({tag, "_pprot"}, 32'(pprot), 32'(e_prot));
    tick();
    check({tag, "_acc_rdy"}, 32'(hreadyout), 32'd0);
    check({tag, "_acc_pen"}, 32'(penable), 32'd1);
    check({tag, "_acc_psel"}, 32'(psel), 32'(e_sel));
    tick();
    check({tag, "_done_rdy"}, 32'(hreadyout), 32'd1);
    check({tag, "_done_resp"}, 32'(hresp), 32'd0);
    check({tag, "_done_psel"}, 32'(psel), 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1; hsel = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hprot = 4'd0; hwdata = '0; hready = 1'b1;
    pready  = 4'hF; pslverr  = 4'h0;
    prdata  = {32'h12345678, 32'h22222222, 32'h11111111, 32'hA0A0A0A0};
    pready3 = 3'b111; pslverr3 = 3'b000;
    prdata3 = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    tick();
    tick();
    check("rst_rdy", 32'(hreadyout), 32'd1);
    check("rst_resp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_pen", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pstrb", 32'(pstrb), 32'd0);
    check("rst_pprot", 32'(pprot), 32'd0);
    rst = 1'b0;
    tick();

    // Word, byte and half writes, issued back to back.
    do_write("w_word", 16'h1004, 3'd2, 32'hDEADBEEF, 4'b0011, 4'b0010, 4'b1111, 3'b011);
    do_write("w_byte", 16'h2003, 3'd0, 32'hAB000000, 4'b0000, 4'b0100, 4'b1000, 3'b110);
    do_write("w_half", 16'h2002, 3'd1, 32'hCDEF0000, 4'b0010, 4'b0100, 4'b1100, 3'b111);

    // Read from slave 3 with two wait cycles; other slaves flag errors that must be ignored.
    pready  = 4'b0111;
    pslverr = 4'b0111;
    ahb_addr(1'b0, 16'h3010, 1'b0, 3'd2, 4'b0001);
    check("rd_setup_rdy", 32'(hreadyout), 32'd0);
    check("rd_setup_psel", 32'(psel), 32'h8);
    check("rd_pstrb", 32'(pstrb), 32'd0);
    check("rd_pwrite", 32'(pwrite), 32'd0);
    check("rd_paddr", 32'(paddr), 32'h010);
    check("rd_pprot", 32'(pprot), 32'b010);
    tick();
    check("rd_acc1_rdy", 32'(hreadyout), 32'd0);
    check("rd_acc1_pen", 32'(penable), 32'd1);
    tick();
    check("rd_acc2_rdy", 32'(hreadyout), 32'd0);
    check("rd_hold_hrdata", hrdata, 32'd0);
    tick();
    pready = 4'hF;
    check("rd_acc3_rdy", 32'(hreadyout), 32'd0);
    tick();
    check("rd_done_rdy", 32'(hreadyout), 32'd1);
    check("rd_done_resp", 32'(hresp), 32'd0);
    check("rd_hrdata", hrdata, 32'h12345678);
    check("rd_done_psel", 32'(psel), 32'd0);
    pslverr = 4'h0;

    // Slave error on slave 0 -> two-cycle ERROR.
    pslverr = 4'b0001;
    ahb_addr(1'b0, 16'h0000, 1'b0, 3'd2, 4'b0000);
    check("se_setup_psel", 32'(psel), 32'h1);
    tick();
    tick();
    check("se_err1_rdy", 32'(hreadyout), 32'd0);
    check("se_err1_resp", 32'(hresp), 32'd1);
    check("se_err1_psel", 32'(psel), 32'd0);
    tick();
    check("se_err2_rdy", 32'(hreadyout), 32'd1);
    check("se_err2_resp", 32'(hresp), 32'd1);
    check("se_hrdata_kept", hrdata, 32'h12345678);
    tick();
    check("se_idle_resp", 32'(hresp), 32'd0);
    check("se_idle_rdy", 32'(hreadyout), 32'd1);
    pslverr = 4'h0;

    // Slave 2 never ready -> timeout after 16 ACCESS cycles.
    pready = 4'b1011;
    ahb_addr(1'b0, 16'h2000, 1'b0, 3'd2, 4'b0000);
    check("to_setup_psel", 32'(psel), 32'h4);
    tick();
    n = 0;
    while (penable && n < 100) begin
      n++;
      tick();
    end
    check("to_access_cycles", 32'(n), 32'd16);
    check("to_psel_drop", 32'(psel), 32'd0);
    check("to_err1_resp", 32'(hresp), 32'd1);
    check("to_err1_rdy", 32'(hreadyout), 32'd0);
    tick();
    check("to_err2_rdy", 32'(hreadyout), 32'd1);
    check("to_err2_resp", 32'(hresp), 32'd1);
    tick();
    check("to_idle_resp", 32'(hresp), 32'd0);
    pready = 4'hF;

    // Oversized transfer -> immediate error; a read is accepted during ERR2.
    ahb_addr(1'b0, 16'h1000, 1'b1, 3'd3, 4'b0000);
    check("sz_err1_resp", 32'(hresp), 32'd1);
    check("sz_err1_rdy", 32'(hreadyout), 32'd0);
    check("sz_err1_psel", 32'(psel), 32'd0);
    tick();
    check("sz_err2_rdy", 32'(hreadyout), 32'd1);
    check("sz_err2_resp", 32'(hresp), 32'd1);
    ahb_addr(1'b0, 16'h1000, 1'b0, 3'd2, 4'b0000);
    check("e2acc_setup_psel", 32'(psel), 32'h2);
    check("e2acc_setup_resp", 32'(hresp), 32'd0);
    tick();
    tick();
    check("e2acc_done_rdy", 32'(hreadyout), 32'd1);
    check("e2acc_hrdata", hrdata, 32'h11111111);

    // BUSY transfer and unselected NONSEQ are ignored.
    hsel = 1'b1; htrans = 2'b01; haddr = 16'h1000; hwrite = 1'b0;
    tick();
    check("busy_rdy", 32'(hreadyout), 32'd1);
    check("busy_psel", 32'(psel), 32'd0);
    hsel = 1'b0; htrans = 2'b10;
    tick();
    check("nosel_rdy", 32'(hreadyout), 32'd1);
    check("nosel_psel", 32'(psel), 32'd0);
    htrans = 2'b00;
    tick();

    // Out-of-range slave on the 3-slave instance.
    ahb_addr(1'b1, 16'h3000, 1'b0, 3'd2, 4'b0000);
    check("oor_err1_rdy", 32'(hreadyout3), 32'd0);
    check("oor_err1_resp", 32'(hresp3), 32'd1);
    check("oor_err1_psel", 32'(psel3), 32'd0);
    tick();
    check("oor_err2_rdy", 32'(hreadyout3), 32'd1);
    check("oor_err2_resp", 32'(hresp3), 32'd1);
    check("oor_err2_psel", 32'(psel3), 32'd0);
    tick();
    check("oor_idle_resp", 32'(hresp3), 32'd0);

    // Reset during ACCESS of a write, then a fresh read.
    ahb_addr(1'b0, 16'h1000, 1'b1, 3'd2, 4'b0000);
    hwdata = 32'h55AA55AA;
    tick();
    tick();
    check("rst_mid_acc_pen", 32'(penable), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_psel", 32'(psel), 32'd0);
    check("rst_mid_pen", 32'(penable), 32'd0);
    check("rst_mid_rdy", 32'(hreadyout), 32'd1);
    check("rst_mid_resp", 32'(hresp), 32'd0);
    check("rst_mid_pwdata", pwdata, 32'd0);
    check("rst_mid_hrdata", hrdata, 32'd0);
    rst = 1'b0;
    tick();
    ahb_addr(1'b0, 16'h3010, 1'b0, 3'd2, 4'b0000);
    n = 0;
    while (!hreadyout && n < 50) begin
      n++;
      tick();
    end
    check("post_rst_wait", 32'(n), 32'd2);
    check("post_rst_hrdata", hrdata, 32'h12345678);
    check("post_rst_resp", 32'(hresp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
